// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
// Holds RV32I opcodes, the shadow-stage entry layout and the memory-wait FSM states.
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
    logic       is_mem;
  } stage_ent_t;

  typedef enum logic {RUN, WAIT} wait_state_t;

  // One-hot of the destination register for an entry that will write it.
  function automatic logic [31:0] rd_onehot(input stage_ent_t e);
    return (e.valid && e.wen) ? (32'd1 << e.rd) : 32'd0;
  endfunction

endpackage

// File: rtl/inst_class_dec.sv
// Combinational RV32I instruction classifier: which sources are read,
// whether rd is written, and whether the instruction is a load / memory op.
module inst_class_dec
  import hazard_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic        o_wen,
  output logic        o_is_load,
  output logic        o_is_mem,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);

  logic w_writes;
  logic w_unused_bits;

  assign o_rd  = i_inst[11:7];
  assign o_rs1 = i_inst[19:15];
  assign o_rs2 = i_inst[24:20];
  assign w_unused_bits = ^{i_inst[31:25], i_inst[14:12]};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    w_writes   = 1'b0;
    o_is_load  = 1'b0;
    o_is_mem   = 1'b0;
    case (i_inst[6:0])
      OP_R: begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
        w_writes   = 1'b1;
      end
      OP_STORE: begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
        o_is_mem   = 1'b1;
      end
      OP_BRANCH: begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      OP_I, OP_JALR: begin
        o_uses_rs1 = 1'b1;
        w_writes   = 1'b1;
      end
      OP_LOAD: begin
        o_uses_rs1 = 1'b1;
        w_writes   = 1'b1;
        o_is_load  = 1'b1;
        o_is_mem   = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: w_writes = 1'b1;
      default: ;
    endcase
  end

  // Writes to x0 are architecturally discarded, so they never create a hazard.
  assign o_wen = w_writes && (o_rd != 5'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-wait stall controller with EX/MEM/WB shadow pipeline.
// Optional build macro HAZARD_PERF_EN adds saturating lu/mw/flush cycle counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255,
  parameter int WAIT_CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        flush,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        stall_mem,
  output logic [31:0] pending_mask,
  output logic        mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_mw_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [WAIT_CW-1:0] L_WAIT_MAX = WAIT_CW'(MEM_WAIT_MAX);

  logic        w_uses_rs1, w_uses_rs2, w_wen, w_is_load, w_is_mem;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_lu, w_mw;
  stage_ent_t  w_id_ent;
  stage_ent_t  r_ex, r_mem, r_wb;

  wait_state_t        r_state, w_state_nxt;
  logic [WAIT_CW-1:0] r_wait_cnt, w_cnt_nxt;
  logic               r_mem_timeout, w_timeout_nxt;

  inst_class_dec u_dec (
    .i_inst     (id_inst),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_wen      (w_wen),
    .o_is_load  (w_is_load),
    .o_is_mem   (w_is_mem),
    .o_rd       (w_rd),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2)
  );

  always_comb begin
    w_id_ent = '0;
    if (id_valid) begin
      w_id_ent.valid   = 1'b1;
      w_id_ent.rd      = w_rd;
      w_id_ent.wen     = w_wen;
      w_id_ent.is_load = w_is_load;
      w_id_ent.is_mem  = w_is_mem;
    end
  end

  assign w_lu = id_valid && r_ex.valid && r_ex.is_load && r_ex.wen &&
                ((w_uses_rs1 && (r_ex.rd == w_rs1)) ||
                 (w_uses_rs2 && (r_ex.rd == w_rs2)));
  assign w_mw = r_mem.valid && r_mem.is_mem && !mem_ready;

  // A flush kills the dependent instruction, so it overrides the load-use stall.
  assign stall_mem    = w_mw;
  assign stall_if     = w_mw || (w_lu && !flush);
  assign stall_id     = stall_if;
  assign bubble_ex    = (w_lu || flush) && !w_mw;
  assign pending_mask = (rd_onehot(r_ex) | rd_onehot(r_mem) | rd_onehot(r_wb)) & ~32'd1;
  assign mem_timeout  = r_mem_timeout;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values (mem_q <= ex_q; wb_q <= mem_q shift correctly).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!w_mw) begin
      r_ex  <= (flush || w_lu) ? stage_ent_t'('0) : w_id_ent;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_cnt_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_wait_cnt;
    w_timeout_nxt = r_mem_timeout;
    case (r_state)
      RUN: begin
        if (w_mw) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = WAIT_CW'(1);
        end
      end
      WAIT: begin
        if (r_wait_cnt == L_WAIT_MAX) w_timeout_nxt = 1'b1;
        if (mem_ready) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else if (r_wait_cnt < L_WAIT_MAX) begin
          w_cnt_nxt = r_wait_cnt + WAIT_CW'(1);
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

`ifdef HAZARD_PERF_EN
  // Only events that actually steer the pipeline are counted (mw > flush > lu).
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cnt    <= '0;
      perf_mw_cnt    <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_lu && !flush && !w_mw && (perf_lu_cnt != '1)) perf_lu_cnt <= perf_lu_cnt + 32'd1;
      if (w_mw && (perf_mw_cnt != '1)) perf_mw_cnt <= perf_mw_cnt + 32'd1;
      if (flush && !w_mw && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
